// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin write-port arbiter and clear sequencer for an 8x8 register file
// Optional feature macro: REGFILE_ARB_PRIO0_EN (requester 0 gets fixed top priority)
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req_valid, req_rd, req_data  per-requester write requests, requester i at slice i
//   req_ready                    combinational one-hot grant
//   clear_req                    pulse requesting that all registers be zeroed
//   clear_busy, clear_done       clear sequence running / finished pulse
//   rf_reg_write, rf_rd, rf_data_in  registered register-file write port
module regfile_wr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      clear_req,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      rf_reg_write,
    output logic [ADDR_W-1:0]         rf_rd,
    output logic [DATA_W-1:0]         rf_data_in
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef REGFILE_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef enum logic [1:0] {ARB, CLEAR, DONE} state_t;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  rr_ptr;
    logic [ADDR_W-1:0] clr_cnt;
    logic              grant_vld;
    logic              ptr_move;
    logic [PTR_W-1:0]  grant_idx;
    int                idx;

    always_comb begin
        state_nxt  = state;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        ptr_move   = 1'b0;
        clear_busy = 1'b0;
        clear_done = 1'b0;
        idx        = 0;
        case (state)
            ARB: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                end else if (PRIO0 && req_valid[0]) begin
                    // Fixed-priority grant to requester 0 leaves the rotation untouched.
                    grant_vld = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        idx = (int'(rr_ptr) + i) % NUM_REQ;
                        if (!grant_vld && req_valid[idx] && !(PRIO0 && idx == 0)) begin
                            grant_vld = 1'b1;
                            grant_idx = PTR_W'(idx);
                            ptr_move  = 1'b1;
                        end
                    end
                end
            end
            CLEAR: begin
                clear_busy = 1'b1;
                if (clr_cnt == '1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                clear_done = 1'b1;
                state_nxt  = ARB;
            end
            default: state_nxt = ARB;
        endcase
        // Nothing may be granted or flagged while reset is asserted.
        if (reset) begin
            grant_vld  = 1'b0;
            clear_busy = 1'b0;
            clear_done = 1'b0;
        end
        req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB;
            rr_ptr       <= '0;
            clr_cnt      <= '0;
            rf_reg_write <= 1'b0;
            rf_rd        <= '0;
            rf_data_in   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ARB: begin
                    rf_reg_write <= grant_vld;
                    if (clear_req) begin
                        clr_cnt <= '0;
                    end
                    // Without a grant rf_rd/rf_data_in keep their last values.
                    if (grant_vld) begin
                        rf_rd      <= req_rd[int'(grant_idx)*ADDR_W +: ADDR_W];
                        rf_data_in <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
                        if (ptr_move) begin
                            rr_ptr <= PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
                        end
                    end
                end
                CLEAR: begin
                    rf_reg_write <= 1'b1;
                    rf_rd        <= clr_cnt;
                    rf_data_in   <= '0;
                    clr_cnt      <= clr_cnt + 1'b1;
                end
                default: begin
                    rf_reg_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single write port of the 8x8-bit register file between NUM_REQ independent writers (e.g. ALU writeback, load unit, debug port) using valid/ready handshakes and round-robin arbitration. Also contains a clear sequencer that zeroes all 8 registers one per cycle on request. All outputs to the register file are registered, so the register file sees clean, one-write-per-cycle traffic.

Parameters:
NUM_REQ, 3, number of write requesters (2..4)
ADDR_W, 3, register address width (8 registers)
DATA_W, 8, register data width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester write request
req_rd  input  NUM_REQ*ADDR_W  per-requester destination; requester i at bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  per-requester write data; requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  combinational grant; a transfer occurs when valid & ready at a rising edge
clear_req  input  1  single-cycle pulse requesting that all registers be cleared
clear_busy  output  1  high while the clear sequence runs
clear_done  output  1  one-cycle pulse after the last clear write
rf_reg_write  output  1  to register file reg_write
rf_rd  output  ADDR_W  to register file rd
rf_data_in  output  DATA_W  to register file data_in

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=ARB, rr_ptr=0, clear counter=0.
- Outputs during and after reset: rf_reg_write=0, rf_rd=0, rf_data_in=0, clear_busy=0, clear_done=0, req_ready=0 while reset is high.
- FSM states: ARB, CLEAR, DONE.
- ARB:
  - If clear_req=1: req_ready all 0; next state CLEAR, counter=0.
  - Otherwise: grant the first requester with valid=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Only the granted requester sees req_ready=1. req_ready is 0 for non-valid requesters.
- Acceptance (grant to requester g at edge N):
  - At edge N, register rf_reg_write=1, rf_rd=req_rd[g], rf_data_in=req_data[g].
  - rr_ptr becomes (g+1) mod NUM_REQ.
  - The register file commits the write at edge N+1. Latency is 1 cycle from handshake to rf_reg_write.
- No grant in a cycle: rf_reg_write=0 next cycle. rf_rd and rf_data_in hold their previous values. rr_ptr is unchanged.
- Requesters must hold valid, rd and data stable until they see ready. A requester that drops valid before being granted loses its place; the arbiter keeps no state for it.
- CLEAR:
  - req_ready all 0; clear_busy=1.
  - Each cycle registers rf_reg_write=1, rf_rd=counter, rf_data_in=0, then increments the counter.
  - After counter=7 is issued, next state DONE. This is 8 cycles total.
  - clear_req is ignored while in CLEAR or DONE.
- DONE: clear_done=1 and clear_busy=0 for one cycle; no write is issued; req_ready all 0; next state ARB. rr_ptr is preserved across the clear.
- Register-file reads stay direct; this block never drives the read ports.
- Reset mid-clear aborts the sequence: state returns to ARB and rf_reg_write goes low. The register contents are whatever the register file's own reset leaves them.
- Same-cycle write to the same rd from two requesters cannot occur, because only one grant is issued per cycle.

Optional Feature:
REGFILE_ARB_PRIO0_EN:
- Defined: requester 0 has fixed highest priority; whenever req_valid[0]=1 in ARB it is granted. Round-robin among requesters 1..NUM_REQ-1 applies only when requester 0 is idle, and a grant to requester 0 does not move rr_ptr.
- Undefined: pure round-robin over all requesters, as described above.

Test Plan:
- After reset, apply req_valid=0 -> rf_reg_write=0, rf_rd=0, rf_data_in=0, req_ready=000, clear_busy=0.
- req_valid=001, rd0=3, data0=0xA5 -> req_ready=001 that cycle; next cycle rf_reg_write=1, rf_rd=3, rf_data_in=0xA5; register file reg 3 reads 0xA5 one cycle later.
- req_valid=111 held for 3 cycles starting with rr_ptr=0 -> grants 0,1,2 in order, one per cycle, with the matching rd/data on rf_* one cycle after each grant; rr_ptr ends at 0.
- Preload regs with 0xFF, then pulse clear_req while req_valid=010 -> that cycle req_ready=000; 8 cycles of rf_reg_write=1 with rf_rd=0..7 and rf_data_in=0; clear_done pulses once; requester 1 is granted the cycle after DONE; all regs read 0 except its target.
- Assert reset in the 4th clear cycle -> next cycle rf_reg_write=0, clear_busy=0, state ARB; clear_done is never pulsed.
- With REGFILE_ARB_PRIO0_EN, req_valid=111 held -> requester 0 is granted every cycle. Drop valid0 -> grants proceed 1,2,1,...
